sound_mix_dac: RTL and testbench
================================

Name: sound_mix_dac

Overview:
- Output stage downstream of the sound register block; replaces the per-channel 8-bit PWM DAC pair.
- Accepts left/right 8-bit unsigned samples (0x80 = midscale) on a load strobe.
- Slew-limits each channel toward its target to suppress clicks, mixes in the PC speaker bit, and drives 1-bit first-order sigma-delta outputs to the board audio pins.

Parameters:
- SPK_LEVEL, 8'd64: amplitude added to each channel while the synchronised speaker bit is 1.
- RAMP_DIV, 16: clocks per one-LSB slew step; legal range 1..65535.

Ports:
- wb_clk_i  input  1  system clock; the only clock.
- wb_rst_i  input  1  synchronous, active-high reset.
- sample_l  input  8  left target sample, unsigned.
- sample_r  input  8  right target sample, unsigned.
- sample_stb  input  1  one-clock pulse; loads both targets.
- speaker  input  1  PC speaker square wave; asynchronous to wb_clk_i.
- mute  input  1  level; ramps both channels to midscale and blocks the speaker.
- ready  output  1  both channels have settled at their effective targets.
- audio_l  output  1  left sigma-delta bitstream.
- audio_r  output  1  right sigma-delta bitstream.

Behaviour:
- Clocking and reset: one clock, wb_clk_i. Reset wb_rst_i is synchronous and active-high; it takes effect on the clock edge only.
- Reset values:
  - tgt_l, tgt_r, cur_l, cur_r = 0x80.
  - Prescaler = 0; speaker synchroniser flops = 0.
  - Accumulators acc_l, acc_r (9-bit) = 0.
  - audio_l, audio_r = 0; ready = 1.
  - Reset asserted mid-ramp abandons the ramp and restores all of these values on the next edge.
- Target load: on sample_stb=1, tgt_l<=sample_l and tgt_r<=sample_r. The stored targets are used from the following cycle.
- Effective target: eff_x = mute ? 0x80 : tgt_x. Stored targets are kept while mute is high, so deasserting mute resumes the ramp toward them.
- Prescaler:
  - Counts 0..RAMP_DIV-1 and wraps.
  - tick = 1 in the cycle the count equals RAMP_DIV-1.
  - With RAMP_DIV=1, tick is 1 every cycle.
- Slew:
  - On tick, cur_x moves one LSB toward eff_x (+1 if below, -1 if above, unchanged if equal).
  - Never overshoots; no 8-bit wrap is possible.
  - A tick coinciding with sample_stb steps toward the old target.
- Speaker path: 2-flop synchroniser gives spk_s, which adds 2 cycles of latency.
- Mix:
  - m_x = min(255, cur_x + (spk_s & ~mute ? SPK_LEVEL : 0)).
  - Computed 9-bit, then saturated to 8 bits. Combinational from registers.
- Sigma-delta:
  - Each cycle, s = {1'b0, acc_x[7:0]} + m_x; acc_x <= s; audio_x <= s[8] (registered).
  - Over any 256 consecutive cycles with constant m_x, the count of ones equals m_x exactly.
  - m_x=0 gives constant 0; m_x=255 gives 255 ones per 256 cycles.
- ready:
  - ready = (cur_l==eff_l) & (cur_r==eff_r), combinational from registers.
  - Drops in the cycle after a strobe that changes a target.
  - Also drops when mute toggles while cur≠0x80.
- Latency: from a change of cur_x to the first audio_x bit reflecting it is 1 cycle. From speaker to output is 3 cycles.
- Simultaneous mute and sample_stb: the target is stored, and the ramp heads to 0x80 while mute=1.

Test Plan:
1. Reset, idle 512 cycles -> ready=1; audio_l and audio_r each show exactly 128 ones in any 256-cycle window after the first 256.
2. RAMP_DIV=4, strobe sample_l=0x84, sample_r=0x80:
   - ready=0 from the next cycle.
   - cur_l steps 0x81..0x84, one step per 4 clocks, and reaches 0x84 within 16 clocks.
   - ready=1 the cycle cur_l==0x84; audio_r unchanged.
3. Settled at 0xFF, speaker=1, SPK_LEVEL=64 -> m saturates to 255; 255 ones per 256 cycles. Speaker=0 -> still 255 ones, since cur=0xFF alone gives m=255.
4. Settled at 0xC0, assert mute:
   - Ramps to 0x80 in 64*RAMP_DIV clocks; speaker toggling has no effect; ready=1 at 0x80.
   - Deassert mute -> ramps back to 0xC0.
5. Strobe 0x00 both channels with RAMP_DIV=1 -> 128 clocks to reach 0x00; audio outputs then stay constant 0.
6. Reset pulsed mid-ramp (cur_l=0xA0) -> next cycle cur_l=0x80, tgt_l=0x80, ready=1, audio outputs 0.

Source files
------------

// File: rtl/sound_mix_dac.sv
// Stereo output stage: slew-limited targets, PC speaker mix and
// first-order sigma-delta bitstreams for the board audio pins.
module sound_mix_dac #(
   parameter logic [7:0]  SPK_LEVEL = 8'd64,
   parameter int unsigned RAMP_DIV  = 16
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic [7:0] sample_l,
   input  logic [7:0] sample_r,
   input  logic       sample_stb,
   input  logic       speaker,
   input  logic       mute,
   output logic       ready,
   output logic       audio_l,
   output logic       audio_r
);

   localparam logic [15:0] DIV_LAST = 16'(RAMP_DIV - 1);

   logic [15:0] presc;
   logic        tick;
   logic [7:0]  tgt_l, tgt_r, cur_l, cur_r;
   logic [7:0]  eff_l, eff_r, m_l, m_r;
   logic        spk_m, spk_s, spk_on;
   logic [8:0]  acc_l, acc_r, s_l, s_r, mix_l, mix_r;

   function automatic logic [7:0] slew(input logic [7:0] cur, input logic [7:0] eff);
      if (cur < eff)
         return cur + 8'd1;
      else if (cur > eff)
         return cur - 8'd1;
      else
         return cur;
   endfunction

   function automatic logic [7:0] sat8(input logic [8:0] v);
      return v[8] ? 8'hFF : v[7:0];
   endfunction

   always_comb begin
      tick   = (presc == DIV_LAST);
      eff_l  = mute ? 8'h80 : tgt_l;
      eff_r  = mute ? 8'h80 : tgt_r;
      spk_on = spk_s & ~mute;
      mix_l  = {1'b0, cur_l} + (spk_on ? {1'b0, SPK_LEVEL} : 9'd0);
      mix_r  = {1'b0, cur_r} + (spk_on ? {1'b0, SPK_LEVEL} : 9'd0);
      m_l    = sat8(mix_l);
      m_r    = sat8(mix_r);
      s_l    = {1'b0, acc_l[7:0]} + {1'b0, m_l};
      s_r    = {1'b0, acc_r[7:0]} + {1'b0, m_r};
      ready  = (cur_l == eff_l) & (cur_r == eff_r);
   end

   // acc[8] is the registered carry, i.e. exactly the audio bit.
   assign audio_l = acc_l[8];
   assign audio_r = acc_r[8];

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         presc <= '0;
         tgt_l <= 8'h80;
         tgt_r <= 8'h80;
         cur_l <= 8'h80;
         cur_r <= 8'h80;
         spk_m <= 1'b0;
         spk_s <= 1'b0;
         acc_l <= '0;
         acc_r <= '0;
      end else begin
         presc <= tick ? '0 : presc + 16'd1;
         if (tick) begin
            cur_l <= slew(cur_l, eff_l);
            cur_r <= slew(cur_r, eff_r);
         end
         if (sample_stb) begin
            tgt_l <= sample_l;
            tgt_r <= sample_r;
         end
         spk_m <= speaker;
         spk_s <= spk_m;
         acc_l <= s_l;
         acc_r <= s_r;
      end
   end

endmodule

// File: tb/tb_sound_mix_dac.sv
// Randomised and directed checks of sound_mix_dac against a cycle-level
// arithmetic model, for RAMP_DIV=4 and RAMP_DIV=1 instances.
module tb_sound_mix_dac;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] sl, sr;
   logic       stb, spk, mute;
   logic [1:0] rdy, al, ar;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   sound_mix_dac #(.SPK_LEVEL(8'd64), .RAMP_DIV(4)) u_dut4 (
      .wb_clk_i(clk), .wb_rst_i(rst), .sample_l(sl), .sample_r(sr),
      .sample_stb(stb), .speaker(spk), .mute(mute),
      .ready(rdy[0]), .audio_l(al[0]), .audio_r(ar[0]));

   sound_mix_dac #(.SPK_LEVEL(8'd64), .RAMP_DIV(1)) u_dut1 (
      .wb_clk_i(clk), .wb_rst_i(rst), .sample_l(sl), .sample_r(sr),
      .sample_stb(stb), .speaker(spk), .mute(mute),
      .ready(rdy[1]), .audio_l(al[1]), .audio_r(ar[1]));

   // behavioural model state per instance
   int div[2] = '{4, 1};
   int m_tgt_l[2], m_tgt_r[2], m_cur_l[2], m_cur_r[2], m_cnt[2];
   int m_s1[2], m_s2[2], m_acc_l[2], m_acc_r[2], m_aud_l[2], m_aud_r[2];

   function automatic int mixsat(input int cur, input int spk_on);
      int v;
      v = cur + (spk_on != 0 ? 64 : 0);
      return (v > 255) ? 255 : v;
   endfunction

   function automatic int toward(input int cur, input int eff);
      if (cur < eff) return cur + 1;
      if (cur > eff) return cur - 1;
      return cur;
   endfunction

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // model advance on every edge, compare 1 time unit later
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         for (int i = 0; i < 2; i++) begin
            if (rst) begin
               m_tgt_l[i] = 128; m_tgt_r[i] = 128;
               m_cur_l[i] = 128; m_cur_r[i] = 128;
               m_cnt[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
               m_acc_l[i] = 0; m_acc_r[i] = 0;
               m_aud_l[i] = 0; m_aud_r[i] = 0;
            end else begin
               int on, tk, el, er;
               on = (m_s2[i] != 0 && !mute) ? 1 : 0;
               m_acc_l[i] = m_acc_l[i] % 256 + mixsat(m_cur_l[i], on);
               m_acc_r[i] = m_acc_r[i] % 256 + mixsat(m_cur_r[i], on);
               m_aud_l[i] = (m_acc_l[i] >= 256) ? 1 : 0;
               m_aud_r[i] = (m_acc_r[i] >= 256) ? 1 : 0;
               tk = (m_cnt[i] == div[i] - 1) ? 1 : 0;
               el = mute ? 128 : m_tgt_l[i];
               er = mute ? 128 : m_tgt_r[i];
               if (tk != 0) begin
                  m_cur_l[i] = toward(m_cur_l[i], el);
                  m_cur_r[i] = toward(m_cur_r[i], er);
               end
               if (stb) begin
                  m_tgt_l[i] = int'(sl);
                  m_tgt_r[i] = int'(sr);
               end
               m_s2[i] = m_s1[i];
               m_s1[i] = int'(spk);
               m_cnt[i] = (tk != 0) ? 0 : m_cnt[i] + 1;
            end
         end
         #1;
         for (int i = 0; i < 2; i++) begin
            int er_exp;
            er_exp = (m_cur_l[i] == (mute ? 128 : m_tgt_l[i])) &&
                     (m_cur_r[i] == (mute ? 128 : m_tgt_r[i])) ? 1 : 0;
            check($sformatf("model ready[%0d]", i), int'(rdy[i]), er_exp);
            check($sformatf("model audio_l[%0d]", i), int'(al[i]), m_aud_l[i]);
            check($sformatf("model audio_r[%0d]", i), int'(ar[i]), m_aud_r[i]);
         end
      end
   end

   int ones_l[2], ones_r[2];

   task automatic window();
      for (int i = 0; i < 2; i++) begin ones_l[i] = 0; ones_r[i] = 0; end
      repeat (256) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            ones_l[i] += int'(al[i]);
            ones_r[i] += int'(ar[i]);
         end
      end
   endtask

   task automatic check_window(input string name, input int want);
      window();
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s ones_l[%0d]", name, i), ones_l[i], want);
         check($sformatf("%s ones_r[%0d]", name, i), ones_r[i], want);
      end
   endtask

   task automatic strobe(input logic [7:0] l, input logic [7:0] r);
      sl = l; sr = r; stb = 1'b1;
      @(negedge clk);
      stb = 1'b0;
   endtask

   // counts negedges until each instance reports ready; -1 on timeout
   task automatic wait_both(input int limit, output int k0, output int k1);
      int k;
      k = 0; k0 = -1; k1 = -1;
      if (rdy[0]) k0 = 0;
      if (rdy[1]) k1 = 0;
      while (rdy !== 2'b11 && k < limit) begin
         @(negedge clk);
         k++;
         if (rdy[0] && k0 < 0) k0 = k;
         if (rdy[1] && k1 < 0) k1 = k;
      end
      check("ready timeout", int'(rdy == 2'b11), 1);
   endtask

   int k0, k1;

   initial begin
      rst = 1'b1; sl = 8'h80; sr = 8'h80; stb = 1'b0; spk = 1'b0; mute = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // idle at midscale
      repeat (256) @(negedge clk);
      check("t1 ready", int'(rdy), 3);
      check_window("t1", 128);

      // small step on left only
      strobe(8'h84, 8'h80);
      check("t2 ready drop", int'(rdy[0]), 0);
      wait_both(100, k0, k1);
      check("t2 settle div4", int'(k0 >= 13 && k0 <= 16), 1);
      check("t2 settle div1", k1, 4);

      // full scale with speaker saturating
      strobe(8'hFF, 8'hFF);
      wait_both(2000, k0, k1);
      spk = 1'b1;
      repeat (4) @(negedge clk);
      check_window("t3 spk1", 255);
      spk = 1'b0;
      repeat (4) @(negedge clk);
      check_window("t3 spk0", 255);

      // mute ramp from 0xC0 with speaker noise
      strobe(8'hC0, 8'hC0);
      wait_both(2000, k0, k1);
      mute = 1'b1;
      #1;
      check("t4 mute drop", int'(rdy), 0);
      k0 = -1; k1 = -1;
      for (int k = 1; k <= 400 && rdy !== 2'b11; k++) begin
         @(negedge clk);
         spk = 1'($urandom);
         if (rdy[0] && k0 < 0) k0 = k;
         if (rdy[1] && k1 < 0) k1 = k;
      end
      check("t4 mute div4", int'(k0 >= 253 && k0 <= 256), 1);
      check("t4 mute div1", k1, 64);
      check_window("t4 muted spk", 128);
      spk = 1'b0;
      mute = 1'b0;
      #1;
      wait_both(400, k0, k1);
      check("t4 unmute div4", int'(k0 >= 253 && k0 <= 256), 1);
      check("t4 unmute div1", k1, 64);
      repeat (4) @(negedge clk);
      check_window("t4 back", 192);

      // midscale to zero
      strobe(8'h80, 8'h80);
      wait_both(400, k0, k1);
      strobe(8'h00, 8'h00);
      wait_both(1000, k0, k1);
      check("t5 zero div4", int'(k0 >= 509 && k0 <= 512), 1);
      check("t5 zero div1", k1, 128);
      check_window("t5", 0);

      // reset mid-ramp
      strobe(8'hC0, 8'hC0);
      repeat (640) @(negedge clk);
      check("t6 mid-ramp busy", int'(rdy[0]), 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t6 ready", int'(rdy), 3);
      check("t6 audio_l", int'(al), 0);
      check("t6 audio_r", int'(ar), 0);
      check_window("t6", 128);

      // random traffic, model-checked every cycle
      for (int n = 0; n < 4000; n++) begin
         @(negedge clk);
         stb = ($urandom_range(15) == 0);
         sl = 8'($urandom);
         sr = 8'($urandom);
         if ($urandom_range(7) == 0) spk = ~spk;
         if ($urandom_range(199) == 0) mute = ~mute;
         rst = ($urandom_range(999) == 0);
         if (stb && $urandom_range(3) == 0) mute = 1'b1;
      end
      @(negedge clk);
      rst = 1'b0; stb = 1'b0;
      repeat (4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
